// File: rtl/servo_pkg.sv
// Shared types and constants for the servo pulse decoder.
package servo_pkg;

    localparam int SERVO_W   = 8;
    localparam int SERVO_MAX = 255;

    // Servo value forced on loss of signal when the failsafe build is used.
    localparam logic [SERVO_W-1:0] FAILSAFE_DEFAULT = 8'd128;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        OFFSET,
        MEASURE
    } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// level_o is delayed to line up with the edge strobes, so the first cycle
// that shows rise_o is also the first cycle that shows level_o high.
// RESET_VAL sets the assumed line level out of reset; presetting to 1
// makes a line that is low at reset release look like a falling edge
// rather than a rising one.
module pwm_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, level_q, rise_q, fall_q;

    // Synchronize the pin, then register the edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= RESET_VAL;
            sync_q  <= RESET_VAL;
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= d_i;
            sync_q  <= meta_q;
            level_q <= sync_q;
            rise_q  <= sync_q & ~level_q;
            fall_q  <= ~sync_q & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_to_servo.sv
// Servo pulse decoder: measures the high time of a servo-style PWM pulse
// and reconstructs the 8-bit command, with loss-of-signal detection.
// Optional build macro PWM_TO_SERVO_FAILSAFE_EN: when defined, servo is
// forced to FAILSAFE_VALUE with one valid strobe as signal_lost rises.
// Assumes 2 <= MIN_CLKS < TIMEOUT_CLKS and STEP_CLKS >= 1.
module pwm_to_servo
    import servo_pkg::*;
#(
    parameter int unsigned         MIN_CLKS       = 100000,
    parameter int unsigned         STEP_CLKS      = 392,
    parameter int unsigned         TIMEOUT_CLKS   = 2500000,
    parameter logic [SERVO_W-1:0]  FAILSAFE_VALUE = FAILSAFE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_in,
    output logic [SERVO_W-1:0] servo,
    output logic               valid,
    output logic               signal_lost
);

`ifdef PWM_TO_SERVO_FAILSAFE_EN
    localparam bit FAILSAFE_EN = 1'b1;
`else
    localparam bit FAILSAFE_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int PS_W  = $clog2(STEP_CLKS + 1);

    localparam logic [CNT_W-1:0]   MIN_C    = CNT_W'(MIN_CLKS);
    localparam logic [CNT_W-1:0]   TO_C     = CNT_W'(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [PS_W-1:0]    STEP_C   = PS_W'(STEP_CLKS);
    localparam logic [PS_W-1:0]    PS_ONE   = PS_W'(1);
    localparam logic [SERVO_W-1:0] STEP_SAT = SERVO_W'(SERVO_MAX);
    localparam logic [SERVO_W-1:0] STEP_ONE = SERVO_W'(1);

    logic lvl, rise, fall;

    pwm_sync_edge #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (pwm_in),
        .level_o (lvl),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hi_q, hi_d;       // high samples seen before this cycle
    logic [CNT_W-1:0]   gap_q, gap_d;     // low clocks spent in IDLE
    logic [PS_W-1:0]    presc_q, presc_d;
    logic [SERVO_W-1:0] step_q, step_d;
    logic [SERVO_W-1:0] servo_q, servo_d;
    logic               valid_q, valid_d;
    logic               lost_q, lost_d;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            hi_q    <= '0;
            gap_q   <= '0;
            presc_q <= '0;
            step_q  <= '0;
            servo_q <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            gap_q   <= gap_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            servo_q <= servo_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state, width measurement, publish and loss detection.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        gap_d   = gap_q;
        presc_d = presc_q;
        step_d  = step_q;
        servo_d = servo_q;
        valid_d = 1'b0;
        lost_d  = lost_q;

        unique case (state_q)
            // Drop any pulse already in progress; only a clean low arms us.
            WAIT_LOW: begin
                if (!lvl) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end
            end

            IDLE: begin
                if (rise) begin
                    // The rising sample is itself the first high sample.
                    state_d = OFFSET;
                    hi_d    = CNT_ONE;
                end else if (gap_q != TO_C) begin
                    gap_d = gap_q + CNT_ONE;
                    if (gap_d == TO_C) lost_d = 1'b1;
                end
            end

            OFFSET, MEASURE: begin
                if (hi_q == TO_C) begin
                    // Stuck high; also wins over a fall landing on this cycle.
                    lost_d  = 1'b1;
                    state_d = WAIT_LOW;
                end else if (fall) begin
                    // Counters already include every high sample of the pulse,
                    // including any prescaler wrap on the last one.
                    servo_d = (state_q == MEASURE) ? step_q : '0;
                    valid_d = 1'b1;
                    lost_d  = 1'b0;
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    hi_d = hi_q + CNT_ONE;
                    if (state_q == OFFSET) begin
                        if (hi_d == MIN_C) begin
                            state_d = MEASURE;
                            presc_d = '0;
                            step_d  = '0;
                        end
                    end else begin
                        presc_d = presc_q + PS_ONE;
                        if (presc_d == STEP_C) begin
                            presc_d = '0;
                            if (step_q != STEP_SAT) step_d = step_q + STEP_ONE;
                        end
                    end
                end
            end

            default: state_d = WAIT_LOW;
        endcase

        if (FAILSAFE_EN && lost_d && !lost_q) begin
            servo_d = FAILSAFE_VALUE;
            valid_d = 1'b1;
        end
    end

    assign servo       = servo_q;
    assign valid       = valid_q;
    assign signal_lost = lost_q;

endmodule
